// File: rtl/monochrome_switch_ctrl_pkg.sv
// Shared definitions for the monochrome switch controller: mode encodings,
// PS/2 set-2 scancodes, controller-response filter and decoder state enum.
package mono_pkg;

    localparam int MODE_W = 2;

    // Output-stage tint modes
    localparam logic [MODE_W-1:0] MODE_COLOR = 2'b00;
    localparam logic [MODE_W-1:0] MODE_GREEN = 2'b01;
    localparam logic [MODE_W-1:0] MODE_AMBER = 2'b10;
    localparam logic [MODE_W-1:0] MODE_MONO  = 2'b11;

    // PS/2 set-2 prefixes and the keys we track
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_LCTRL = 8'h14;  // E0-prefixed: right Ctrl
    localparam logic [7:0] SC_LALT  = 8'h11;  // E0-prefixed: right Alt
    localparam logic [7:0] SC_F11   = 8'h78;
    localparam logic [7:0] SC_F12   = 8'h07;

    // Controller responses that must never be taken as key makes
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERRF   = 8'hFF;

    // Pause sends E1 followed by seven more bytes that carry no key meaning
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        KS_IDLE    = 3'd0,
        KS_EXT     = 3'd1,
        KS_BRK     = 3'd2,
        KS_EXT_BRK = 3'd3,
        KS_PAUSE   = 3'd4
    } kbd_state_e;

    // True for bytes the keyboard controller emits as status, not keys
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_ACK)  || (b == SC_RESEND) ||
               (b == SC_ECHO)   || (b == SC_ERR0) || (b == SC_ERRF);
    endfunction

endpackage

// File: rtl/monochrome_switch_ctrl_if.sv
// Bus bundle between the keyboard/CPU/video sources and the switch controller.
// master = the side that produces requests and vsync, slave = the controller.
interface monochrome_switch_ctrl_if;
    import mono_pkg::*;

    logic [7:0]        kb_data;
    logic              kb_valid;
    logic              io_wr;
    logic [MODE_W-1:0] io_data;
    logic              vga_vsync;
    logic [MODE_W-1:0] monochrome_switcher;
    logic              mode_pending;

    modport master (
        output kb_data, kb_valid, io_wr, io_data, vga_vsync,
        input  monochrome_switcher, mode_pending
    );

    modport slave (
        input  kb_data, kb_valid, io_wr, io_data, vga_vsync,
        output monochrome_switcher, mode_pending
    );
endinterface

// File: rtl/monochrome_switch_ctrl_ps2_key_tracker.sv
// PS/2 set-2 prefix decoder that tracks Ctrl/Alt/F11/F12 held state and
// flags the Ctrl+Alt+F11 / Ctrl+Alt+F12 hotkeys.
// hk_next/hk_reset are decoded in the same cycle as the kb_valid strobe that
// carries the F11/F12 make, so the parent can register the request on the
// following edge just like a CPU write.
module ps2_key_tracker
    import mono_pkg::*;
(
    input  logic       clk_vga,
    input  logic       rst_n,
    input  logic [7:0] kb_data,
    input  logic       kb_valid,
    output logic       hk_next,
    output logic       hk_reset
);

    kbd_state_e state_q, state_d;
    logic [2:0] skip_q,  skip_d;
    logic       lctrl_q, lctrl_d;
    logic       rctrl_q, rctrl_d;
    logic       lalt_q,  lalt_d;
    logic       ralt_q,  ralt_d;
    logic       f11_q,   f11_d;
    logic       f12_q,   f12_d;

    logic ctrl_held;
    logic alt_held;

    assign ctrl_held = lctrl_q | rctrl_q;
    assign alt_held  = lalt_q  | ralt_q;

    // Prefix FSM, flag updates and hotkey decode for the current byte
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        lctrl_d  = lctrl_q;
        rctrl_d  = rctrl_q;
        lalt_d   = lalt_q;
        ralt_d   = ralt_q;
        f11_d    = f11_q;
        f12_d    = f12_q;
        hk_next  = 1'b0;
        hk_reset = 1'b0;

        if (kb_valid) begin
            case (state_q)
                KS_IDLE: begin
                    if (kb_data == SC_E0) begin
                        state_d = KS_EXT;
                    end else if (kb_data == SC_F0) begin
                        state_d = KS_BRK;
                    end else if (kb_data == SC_E1) begin
                        state_d = KS_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else if (!is_ignored(kb_data)) begin
                        // Base-key make; a repeat of a held key must not refire
                        case (kb_data)
                            SC_LCTRL: lctrl_d = 1'b1;
                            SC_LALT:  lalt_d  = 1'b1;
                            SC_F11: begin
                                f11_d   = 1'b1;
                                hk_next = ctrl_held & alt_held & ~f11_q;
                            end
                            SC_F12: begin
                                f12_d    = 1'b1;
                                hk_reset = ctrl_held & alt_held & ~f12_q;
                            end
                            default: ;
                        endcase
                    end
                end

                KS_EXT: begin
                    if (kb_data == SC_F0) begin
                        state_d = KS_EXT_BRK;
                    end else begin
                        state_d = KS_IDLE;
                        if (kb_data == SC_LCTRL) rctrl_d = 1'b1;
                        if (kb_data == SC_LALT)  ralt_d  = 1'b1;
                    end
                end

                KS_BRK: begin
                    state_d = KS_IDLE;
                    case (kb_data)
                        SC_LCTRL: lctrl_d = 1'b0;
                        SC_LALT:  lalt_d  = 1'b0;
                        SC_F11:   f11_d   = 1'b0;
                        SC_F12:   f12_d   = 1'b0;
                        default: ;
                    endcase
                end

                KS_EXT_BRK: begin
                    state_d = KS_IDLE;
                    if (kb_data == SC_LCTRL) rctrl_d = 1'b0;
                    if (kb_data == SC_LALT)  ralt_d  = 1'b0;
                end

                KS_PAUSE: begin
                    // Pause bytes are swallowed whole so its embedded 14s never touch Ctrl
                    if (skip_q == 3'd1) begin
                        state_d = KS_IDLE;
                        skip_d  = 3'd0;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end

                default: begin
                    state_d = KS_IDLE;
                    skip_d  = 3'd0;
                end
            endcase
        end
    end

    // Decoder state and key flags
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KS_IDLE;
            skip_q  <= 3'd0;
            lctrl_q <= 1'b0;
            rctrl_q <= 1'b0;
            lalt_q  <= 1'b0;
            ralt_q  <= 1'b0;
            f11_q   <= 1'b0;
            f12_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            lctrl_q <= lctrl_d;
            rctrl_q <= rctrl_d;
            lalt_q  <= lalt_d;
            ralt_q  <= ralt_d;
            f11_q   <= f11_d;
            f12_q   <= f12_d;
        end
    end

endmodule

// File: rtl/monochrome_switch_ctrl.sv
// Monochrome switch controller: merges keyboard hotkeys and CPU writes into a
// pending tint request and commits it to the VGA output stage at vsync so a
// frame never changes tint mid-scan.
module monochrome_switch_ctrl
    import mono_pkg::*;
#(
    parameter logic [MODE_W-1:0] RESET_MODE     = MODE_COLOR,
    parameter bit                VSYNC_ACT_LOW  = 1'b1,
    parameter bit                APPLY_ON_VSYNC = 1'b1
) (
    input  logic                     clk_vga,
    input  logic                     rst_n,
    monochrome_switch_ctrl_if.slave  bus
);

    logic              hk_next;
    logic              hk_reset;

    logic [MODE_W-1:0] switcher_q,     switcher_d;
    logic [MODE_W-1:0] pend_mode_q,    pend_mode_d;
    logic              mode_pending_q, mode_pending_d;
    logic              vs_q,           vs_d;

    logic              vs_edge;
    logic              commit;
    logic              req_valid;
    logic [MODE_W-1:0] req_mode;
    logic [MODE_W-1:0] base_mode;

    ps2_key_tracker u_key_tracker (
        .clk_vga  (clk_vga),
        .rst_n    (rst_n),
        .kb_data  (bus.kb_data),
        .kb_valid (bus.kb_valid),
        .hk_next  (hk_next),
        .hk_reset (hk_reset)
    );

    // Normalise vsync polarity and detect its assertion edge
    always_comb begin
        vs_d    = bus.vga_vsync ^ VSYNC_ACT_LOW;
        vs_edge = vs_d & ~vs_q;
        commit  = APPLY_ON_VSYNC ? (vs_edge & mode_pending_q) : mode_pending_q;
    end

    // Request arbitration: CPU write wins over a hotkey in the same cycle;
    // NEXT chains from the pending mode so two presses advance twice.
    always_comb begin
        base_mode = mode_pending_q ? pend_mode_q : switcher_q;
        req_valid = bus.io_wr | hk_next | hk_reset;
        if (bus.io_wr) begin
            req_mode = bus.io_data;
        end else if (hk_reset) begin
            req_mode = MODE_COLOR;
        end else begin
            req_mode = base_mode + 2'd1;
        end
    end

    // Pending/commit update; a request coinciding with a commit waits for the next one
    always_comb begin
        switcher_d     = commit ? pend_mode_q : switcher_q;
        pend_mode_d    = req_valid ? req_mode : pend_mode_q;
        mode_pending_d = req_valid | (mode_pending_q & ~commit);
    end

    // Committed mode, pending request and vsync history
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            switcher_q     <= RESET_MODE;
            pend_mode_q    <= RESET_MODE;
            mode_pending_q <= 1'b0;
            vs_q           <= 1'b0;
        end else begin
            switcher_q     <= switcher_d;
            pend_mode_q    <= pend_mode_d;
            mode_pending_q <= mode_pending_d;
            vs_q           <= vs_d;
        end
    end

    assign bus.monochrome_switcher = switcher_q;
    assign bus.mode_pending        = mode_pending_q;

endmodule

// File: tb/tb_monochrome_switch_ctrl.sv
// Directed bench for monochrome_switch_ctrl with hand-computed expectations.
module tb_monochrome_switch_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    monochrome_switch_ctrl_if bus_if ();

    monochrome_switch_ctrl dut (
        .clk_vga (clk),
        .rst_n   (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            $display("[TB] ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus_if.kb_data  = b;
        bus_if.kb_valid = 1'b1;
        tick();
        bus_if.kb_valid = 1'b0;
    endtask

    task automatic io_write(input logic [1:0] m);
        bus_if.io_data = m;
        bus_if.io_wr   = 1'b1;
        tick();
        bus_if.io_wr   = 1'b0;
    endtask

    task automatic vsync_frame();
        bus_if.vga_vsync = 1'b0;
        tick();
        bus_if.vga_vsync = 1'b1;
        tick();
    endtask

    task automatic reset_dut();
        bus_if.kb_valid  = 1'b0;
        bus_if.io_wr     = 1'b0;
        bus_if.vga_vsync = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus_if.kb_data   = 8'h00;
        bus_if.kb_valid  = 1'b0;
        bus_if.io_wr     = 1'b0;
        bus_if.io_data   = 2'b00;
        bus_if.vga_vsync = 1'b1;
        rst_n = 1'b0;

        // Reset state
        reset_dut();
        check_eq("reset_sw", bus_if.monochrome_switcher, 8'h0);
        check_eq("reset_pend", bus_if.mode_pending, 8'h0);

        // Ctrl+Alt+F11 from colour, commit at vsync
        send(8'h14); send(8'h11);
        check_eq("t1_no_pend_yet", bus_if.mode_pending, 8'h0);
        send(8'h78);
        check_eq("t1_pend", bus_if.mode_pending, 8'h1);
        bus_if.vga_vsync = 1'b0;
        #1;
        check_eq("t1_pre_edge_sw", bus_if.monochrome_switcher, 8'h0);
        check_eq("t1_pre_edge_pend", bus_if.mode_pending, 8'h1);
        tick();
        check_eq("t1_commit_sw", bus_if.monochrome_switcher, 8'h1);
        check_eq("t1_commit_pend", bus_if.mode_pending, 8'h0);
        bus_if.vga_vsync = 1'b1;
        tick();

        // Typematic F11 repeats fire once; status bytes ignored
        reset_dut();
        send(8'hAA); send(8'h14); send(8'hFA); send(8'h11);
        send(8'h78); send(8'h78); send(8'h78);
        check_eq("t2_pend", bus_if.mode_pending, 8'h1);
        vsync_frame();
        check_eq("t2_one_advance", bus_if.monochrome_switcher, 8'h1);

        // Right Ctrl/Alt, wrap 11->00 then 00->01 after F11 break
        reset_dut();
        io_write(2'b11);
        vsync_frame();
        check_eq("t3_start_mono", bus_if.monochrome_switcher, 8'h3);
        send(8'hE0); send(8'h14); send(8'hE0); send(8'h11);
        send(8'h78);
        check_eq("t3_pend", bus_if.mode_pending, 8'h1);
        check_eq("t3_sw_held", bus_if.monochrome_switcher, 8'h3);
        send(8'hF0); send(8'h78);
        send(8'h78);
        vsync_frame();
        check_eq("t3_two_steps", bus_if.monochrome_switcher, 8'h1);
        check_eq("t3_pend_clr", bus_if.mode_pending, 8'h0);

        // Pause sequence never sets Ctrl
        reset_dut();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h11); send(8'h78);
        check_eq("t4_no_hotkey", bus_if.mode_pending, 8'h0);
        send(8'h14); send(8'hF0); send(8'h78); send(8'h78);
        check_eq("t4_idle_after_pause", bus_if.mode_pending, 8'h1);
        vsync_frame();
        check_eq("t4_sw", bus_if.monochrome_switcher, 8'h1);

        // io_wr beats F12 hotkey in the same cycle
        reset_dut();
        send(8'h14); send(8'h11);
        bus_if.kb_data  = 8'h07;
        bus_if.kb_valid = 1'b1;
        bus_if.io_data  = 2'b10;
        bus_if.io_wr    = 1'b1;
        tick();
        bus_if.kb_valid = 1'b0;
        bus_if.io_wr    = 1'b0;
        check_eq("t5_pend", bus_if.mode_pending, 8'h1);
        vsync_frame();
        check_eq("t5_io_wins", bus_if.monochrome_switcher, 8'h2);

        // Async reset mid-frame drops the pending request
        reset_dut();
        io_write(2'b10);
        check_eq("t6_pend", bus_if.mode_pending, 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_sw", bus_if.monochrome_switcher, 8'h0);
        check_eq("t6_async_pend", bus_if.mode_pending, 8'h0);
        tick();
        rst_n = 1'b1;
        tick();
        vsync_frame();
        check_eq("t6_vsync_noop_sw", bus_if.monochrome_switcher, 8'h0);
        check_eq("t6_vsync_noop_pend", bus_if.mode_pending, 8'h0);

        // Request on the edge cycle waits for the next edge; then F12 hotkey
        reset_dut();
        io_write(2'b01);
        bus_if.vga_vsync = 1'b0;
        bus_if.io_data   = 2'b10;
        bus_if.io_wr     = 1'b1;
        tick();
        bus_if.io_wr     = 1'b0;
        check_eq("t7_edge_sw", bus_if.monochrome_switcher, 8'h1);
        check_eq("t7_edge_pend", bus_if.mode_pending, 8'h1);
        bus_if.vga_vsync = 1'b1;
        tick();
        check_eq("t7_no_commit_inactive", bus_if.monochrome_switcher, 8'h1);
        vsync_frame();
        check_eq("t7_next_edge_sw", bus_if.monochrome_switcher, 8'h2);
        send(8'h14); send(8'h11); send(8'h07);
        check_eq("t7_f12_pend", bus_if.mode_pending, 8'h1);
        vsync_frame();
        check_eq("t7_f12_sw", bus_if.monochrome_switcher, 8'h0);
        send(8'h07);
        check_eq("t7_f12_repeat", bus_if.mode_pending, 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
